xc_malu_long_seq: RTL
=====================

# xc_malu_long_seq

Sequencer and state holder for the multi-precision arithmetic instructions (xc.madd.3, xc.msub.3, xc.macc, xc.mmul.3). It sits between the MALU issue interface and a single shared 32-bit add/subtract datapath. It owns the state machine, the 64-bit accumulator, the carry/borrow bit and the multiply step counter, and it performs the 32-step shift-add multiply. It returns a 64-bit result through a valid/ready handshake.

## Interface
- No parameters; all widths fixed.
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  reset; synchronous, active-low.
- valid  in  1  request present; held high with operands and uop stable until ready.
- flush  in  1  abandon current operation; synchronous.
- uop_madd, uop_msub, uop_macc, uop_mmul  in  1 each  operation select; priority madd > msub > macc > mmul if several are set.
- rs1, rs2, rs3  in  32 each  operands.
- ready  out  1  result valid this cycle; completes the handshake.
- result  out  64  operation result; meaningful only while ready=1.

## Operation
- States: IDLE, MDR, MSUB_1, MACC_1, MMUL_1, MMUL_2, DONE. Registers: acc[63:0], carry, count[5:0].
- Internal 32-bit adder: sum = lhs + (sub ? ~rhs : rhs) + cin; cout = carry out of bit 31. For subtract, cin=1 and borrow = ~cout.
- IDLE with valid=0, or with valid=1 and no uop bit set: no state change.
- madd (IDLE, valid): sum = rs1 + rs2 + rs3[0]. ready=1 combinationally in the same cycle. result = {31'b0, cout, sum}. Stays in IDLE. acc/carry are not written.
- msub:
  - IDLE: acc <= {32'b0, rs1-rs2}, carry <= borrow. Go to MSUB_1.
  - MSUB_1: acc[31:0] <= acc[31:0] - rs3[0], carry <= carry | borrow. Go to DONE.
  - DONE: result = {31'b0, carry, acc[31:0]}.
- macc:
  - IDLE: acc[31:0] <= rs2 + rs3, carry <= cout. Go to MACC_1.
  - MACC_1: acc[63:32] <= rs1 + carry. Carry out of bit 63 is dropped. Go to DONE.
  - DONE: result = acc.
- mmul:
  - IDLE: acc <= {32'b0, rs2}, count <= 0. Go to MDR.
  - MDR, each cycle: {c, s} = acc[63:32] + (acc[0] ? rs1 : 0); acc <= {c, s, acc[31:1]}; count <= count+1. Leave for MMUL_1 when count==31, after that cycle's step.
  - At MMUL_1 entry, acc = rs1*rs2 (unsigned).
  - MMUL_1: acc[31:0] <= acc[31:0] + rs3, carry <= cout.
  - MMUL_2: acc[63:32] <= acc[63:32] + carry. This cannot overflow.
  - DONE: result = acc.
- DONE: ready=1 for exactly one cycle, then IDLE. acc/carry/count hold their values in DONE.
- ready=0 in every state other than DONE, except for madd in IDLE. result is 0 whenever ready=0.

## Timing
- Latency measured from the cycle valid is first high in IDLE (cycle 0) to the ready cycle:
  - madd: 0
  - msub: 2
  - macc: 2
  - mmul: 35 (IDLE at 0, MDR 1–32, MMUL_1 33, MMUL_2 34, DONE 35)
- Back-to-back: if valid is high in the cycle after DONE, a new operation starts in that IDLE cycle. No bubble beyond the DONE cycle.
- flush=1 in any cycle: next state IDLE, ready forced 0 in that cycle, and acc/carry/count are not updated. flush takes precedence over valid and over the FSM transition.
- Reset (g_resetn=0 at an edge): state IDLE, acc=0, carry=0, count=0. ready=0 and result=0 while g_resetn=0, including a madd request. Reset mid-operation aborts with no ready.
- Changing valid or the operands mid-sequence is illegal and the result is undefined. The bench must not do it.

## Test plan
- madd: rs1=FFFFFFFF, rs2=00000001, rs3=00000001. Required: ready in cycle 0, result=00000001_00000001.
- msub: rs1=0, rs2=0, rs3=1. Required: ready in cycle 2, result=00000001_FFFFFFFF. Repeat with rs1=5, rs2=3, rs3=0. Required: result=00000000_00000002.
- macc: rs1=00000005, rs2=FFFFFFFF, rs3=00000002. Required: ready in cycle 2, result=00000006_00000001.
- mmul: rs1=rs2=rs3=FFFFFFFF. Required: ready in cycle 35, result=FFFFFFFF_00000000. Repeat with rs1=3, rs2=7, rs3=0. Required: result=00000000_00000015.
- flush in cycle 10 of an mmul. Required: no ready, state IDLE in cycle 11. A madd in cycle 11 with rs1=1, rs2=2, rs3=0 gives ready in cycle 11 and result=00000000_00000003.
- g_resetn low in cycle 1 of a macc. Required: no ready, acc/carry/count read 0. An msub issued after reset release completes normally with 2-cycle latency.

Source files
------------

// File: rtl/xc_malu_long_seq.sv
// Multi-cycle sequencer for xc.madd.3 / xc.msub.3 / xc.macc / xc.mmul.3.
// Owns a 64-bit accumulator, a carry/borrow bit, a step counter and one shared 32-bit adder.
module xc_malu_long_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rs3,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [2:0] {IDLE, MDR, MSUB_1, MACC_1, MMUL_1, MMUL_2, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc, acc_nxt;
  logic        carry, carry_nxt;
  logic [5:0]  count, count_nxt;

  logic        sel_madd, sel_msub, sel_macc, sel_mmul;
  logic [31:0] add_lhs, add_rhs, add_sum;
  logic        add_sub, add_cin, add_cout;

  assign sel_madd = uop_madd;
  assign sel_msub = uop_msub & ~uop_madd;
  assign sel_macc = uop_macc & ~uop_madd & ~uop_msub;
  assign sel_mmul = uop_mmul & ~uop_madd & ~uop_msub & ~uop_macc;

  // Shared adder; subtraction is lhs + ~rhs + 1, so borrow is the inverted carry out.
  assign {add_cout, add_sum} = {1'b0, add_lhs} + {1'b0, add_sub ? ~add_rhs : add_rhs}
                             + {32'b0, add_cin};

  always_comb begin
    add_lhs = 32'b0;
    add_rhs = 32'b0;
    add_sub = 1'b0;
    add_cin = 1'b0;
    case (state)
      IDLE: begin
        add_lhs = sel_macc ? rs2 : rs1;
        add_rhs = sel_macc ? rs3 : rs2;
        add_sub = sel_msub;
        add_cin = sel_msub | (sel_madd & rs3[0]);
      end
      MSUB_1: begin
        add_lhs = acc[31:0];
        add_rhs = {31'b0, rs3[0]};
        add_sub = 1'b1;
        add_cin = 1'b1;
      end
      MACC_1: begin
        add_lhs = rs1;
        add_cin = carry;
      end
      MDR: begin
        add_lhs = acc[63:32];
        add_rhs = acc[0] ? rs1 : 32'b0;
      end
      MMUL_1: begin
        add_lhs = acc[31:0];
        add_rhs = rs3;
      end
      MMUL_2: begin
        add_lhs = acc[63:32];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    carry_nxt = carry;
    count_nxt = count;
    ready     = 1'b0;
    result    = 64'b0;
    case (state)
      IDLE: if (valid) begin
        if (sel_madd) begin
          ready  = 1'b1;
          result = {31'b0, add_cout, add_sum};
        end else if (sel_msub) begin
          acc_nxt   = {32'b0, add_sum};
          carry_nxt = ~add_cout;
          state_nxt = MSUB_1;
        end else if (sel_macc) begin
          acc_nxt[31:0] = add_sum;
          carry_nxt     = add_cout;
          state_nxt     = MACC_1;
        end else if (sel_mmul) begin
          acc_nxt   = {32'b0, rs2};
          count_nxt = 6'd0;
          state_nxt = MDR;
        end
      end
      MSUB_1: begin
        acc_nxt[31:0] = add_sum;
        carry_nxt     = carry | ~add_cout;
        state_nxt     = DONE;
      end
      MACC_1: begin
        acc_nxt[63:32] = add_sum;
        state_nxt      = DONE;
      end
      MDR: begin
        // One shift-add step: multiplier bits leave at the bottom as product bits enter at the top.
        acc_nxt   = {add_cout, add_sum, acc[31:1]};
        count_nxt = count + 6'd1;
        if (count == 6'd31) state_nxt = MMUL_1;
      end
      MMUL_1: begin
        acc_nxt[31:0] = add_sum;
        carry_nxt     = add_cout;
        state_nxt     = MMUL_2;
      end
      MMUL_2: begin
        acc_nxt[63:32] = add_sum;
        state_nxt      = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        result    = sel_msub ? {31'b0, carry, acc[31:0]} : acc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush || !g_resetn) begin
      state_nxt = IDLE;
      acc_nxt   = acc;
      carry_nxt = carry;
      count_nxt = count;
      ready     = 1'b0;
      result    = 64'b0;
    end
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
      acc   <= 64'b0;
      carry <= 1'b0;
      count <= 6'd0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      count <= count_nxt;
    end
  end

endmodule
